lsu_mem_master: RTL

- Load/store initiator between the core's execute/memory stage and the word-wide data memory.
- Accepts one byte, halfword or word load/store request at a time.
- Translates byte addresses to word addresses and drives the memory's rd_en/wr_en/m_addr/m_wr_dat.
- Extracts and sign/zero-extends load data; the memory has no byte enables, so sub-word stores use read-modify-write.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_mem_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory master.
//   lsu_state_e    : controller states
//   SZ_B/SZ_H/SZ_W : request size encodings (3 is illegal)
//   ERR_*          : response error codes
//   is_misaligned  : alignment / legal-size check on a request
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_MERGE,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // The illegal size code is folded into the misalign error.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic shared by loads and sub-word stores.
//   word_in     : word read from memory
//   st_data     : right-aligned store data (byte uses [7:0], half uses [15:0])
//   lane        : byte address bits [1:0]
//   size        : SZ_B / SZ_H / SZ_W
//   is_unsigned : zero-extend instead of sign-extend sub-word loads
//   ld_data     : selected and extended load value
//   merged      : word_in with the addressed byte/half replaced by st_data
module lsu_align import lsu_pkg::*; (
  input  logic [31:0] word_in,
  input  logic [15:0] st_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the lane, then extend to 32 bits.
  always_comb begin
    byte_sel = word_in[7:0];
    case (lane)
      2'd0: byte_sel = word_in[7:0];
      2'd1: byte_sel = word_in[15:8];
      2'd2: byte_sel = word_in[23:16];
      2'd3: byte_sel = word_in[31:24];
      default: byte_sel = word_in[7:0];
    endcase
    half_sel = lane[1] ? word_in[31:16] : word_in[15:0];
    case (size)
      SZ_B:    ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = word_in;
    endcase
  end

  // Store path: the memory has no byte enables, so the untouched lanes
  // come from the word just read back.
  always_comb begin
    merged = word_in;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0: merged[7:0]   = st_data[7:0];
          2'd1: merged[15:8]  = st_data[7:0];
          2'd2: merged[23:16] = st_data[7:0];
          2'd3: merged[31:24] = st_data[7:0];
          default: merged = word_in;
        endcase
      end
      SZ_H: begin
        if (lane[1]) merged[31:16] = st_data;
        else         merged[15:0]  = st_data;
      end
      default: merged = word_in;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for a word-wide
// data memory without byte enables (sub-word stores use read-modify-write).
//   clk, reset      : clock, synchronous active-high reset
//   req_*           : core request (valid/ready handshake, accepted in IDLE)
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : extended load data (0 for stores/errors), held
//   resp_err        : 0 ok, 1 misaligned/illegal size, 2 out of range, held
//   m_addr          : word address to memory
//   m_wr_dat        : write data to memory
//   rd_en / wr_en   : memory strobes
//   m_rd_dat        : memory read data, valid the cycle after rd_en
// Optional macro LSU_PERF_CNT_EN adds saturating counters ld_cnt, st_cnt
// and err_cnt that count completed responses by type.
module lsu_mem_master import lsu_pkg::*; #(
  parameter int MEM_WORDS = 1024,
  parameter int WADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_dat,
  output logic        rd_en,
  output logic        wr_en,
  input  logic [31:0] m_rd_dat
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt,
  output logic [31:0] err_cnt
`endif
);

  lsu_state_e  state, next_state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  acc_err;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // Misalignment outranks the range check.
  always_comb begin
    if (is_misaligned(req_size, req_addr[1:0]))
      acc_err = ERR_MISALIGN;
    else if (|req_addr[31:WADDR_W+2])
      acc_err = ERR_RANGE;
    else
      acc_err = ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // All handshake and memory strobes are decoded from the registered state.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err != ERR_NONE)  next_state = ST_RESP;
          else if (!req_we)         next_state = ST_RD;
          else if (req_size == SZ_W) next_state = ST_WR;
          else                      next_state = ST_RD;
        end
      end
      ST_RD: begin
        rd_en      = 1'b1;
        next_state = we_q ? ST_MERGE : ST_CAP;
      end
      ST_CAP:   next_state = ST_RESP;
      ST_MERGE: next_state = ST_WR;
      ST_WR: begin
        wr_en      = 1'b1;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .word_in     (m_rd_dat),
    .st_data     (wdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  // Response registers are only written on the cycle before RESP so they
  // hold their last value throughout the next operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0000;
      m_addr     <= 32'h0;
      m_wr_dat   <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            m_addr  <= {{(32-WADDR_W){1'b0}}, req_addr[WADDR_W+1:2]};
            if (req_we && req_size == SZ_W && acc_err == ERR_NONE)
              m_wr_dat <= req_wdata;
            if (acc_err != ERR_NONE) begin
              resp_rdata <= 32'h0;
              resp_err   <= acc_err;
            end
          end
        end
        ST_CAP: begin
          resp_rdata <= ld_data;
          resp_err   <= ERR_NONE;
        end
        ST_MERGE: m_wr_dat <= merged;
        ST_WR: begin
          resp_rdata <= 32'h0;
          resp_err   <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt  <= 32'h0;
      st_cnt  <= 32'h0;
      err_cnt <= 32'h0;
    end else if (resp_valid) begin
      if (resp_err != ERR_NONE) begin
        if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      end else if (we_q) begin
        if (st_cnt != 32'hFFFF_FFFF) st_cnt <= st_cnt + 32'd1;
      end else begin
        if (ld_cnt != 32'hFFFF_FFFF) ld_cnt <= ld_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
